// File: rtl/ball_motion_if.sv
// ball_motion_if: paddle positions in, ball position, scores and event pulses out.
interface ball_motion_if;
  logic [9:0] player_paddle;
  logic [9:0] ai_paddle;
  logic [9:0] ball_pos_x;
  logic [9:0] ball_pos_y;
  logic [3:0] player_score;
  logic [3:0] ai_score;
  logic       paddle_hit;
  logic       point_player;
  logic       point_ai;
  logic       game_over;
  modport master (
    input  player_paddle, ai_paddle,
    output ball_pos_x, ball_pos_y, player_score, ai_score,
           paddle_hit, point_player, point_ai, game_over
  );
  modport slave (
    output player_paddle, ai_paddle,
    input  ball_pos_x, ball_pos_y, player_score, ai_score,
           paddle_hit, point_player, point_ai, game_over
  );
endinterface

// File: rtl/ball_motion.sv
// ball_motion: Pong ball physics, paddle/wall reflection, scoring and serve/play/over sequencing.
module ball_motion #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int PLAYER_X    = 16,
  parameter int AI_X        = 616,
  parameter int SPEED       = 2,
  parameter int STEP_DIV    = 416667,
  parameter int SERVE_STEPS = 60,
  parameter int WIN_SCORE   = 7
) (
  input logic          clk,
  input logic          reset,
  ball_motion_if.master bus
);
  typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;
  localparam int CX   = (SCREEN_W - BALL_SIZE) / 2;
  localparam int CY   = (SCREEN_H - BALL_SIZE) / 2;
  localparam int F    = PLAYER_X + PADDLE_W;
  localparam int YMAX = SCREEN_H - BALL_SIZE;
  localparam int SW   = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam int VW   = SERVE_STEPS > 1 ? $clog2(SERVE_STEPS) : 1;
  state_t        state_q;
  logic [SW-1:0] step_q;
  logic [VW-1:0] serve_q;
  logic [9:0]    x_q, y_q, x_d, y_d;
  logic          dx_q, dy_q, dy_d;
  logic [3:0]    ps_q, as_q, ps_n, as_n;
  logic          hit_q, pp_q, pa_q, go_q;
  logic [10:0]   xe, ye, pe, ae;
  logic          strobe, serve_done, ovl_p, ovl_a, hit_l, hit_r, miss_l, miss_r, win;
  always_comb begin
    xe         = {1'b0, x_q};
    ye         = {1'b0, y_q};
    pe         = {1'b0, bus.player_paddle};
    ae         = {1'b0, bus.ai_paddle};
    strobe     = step_q == SW'(STEP_DIV - 1);
    serve_done = serve_q == VW'(SERVE_STEPS - 1);
    ovl_p      = ye + 11'(BALL_SIZE) > pe && ye < pe + 11'(PADDLE_H);
    ovl_a      = ye + 11'(BALL_SIZE) > ae && ye < ae + 11'(PADDLE_H);
    hit_l      = !dx_q && xe >= 11'(F) && xe < 11'(F + SPEED) && ovl_p;
    hit_r      = dx_q && xe + 11'(BALL_SIZE) <= 11'(AI_X) && xe + 11'(BALL_SIZE + SPEED) > 11'(AI_X) && ovl_a;
    miss_l     = !dx_q && xe < 11'(SPEED) && !hit_l;
    miss_r     = dx_q && xe + 11'(BALL_SIZE + SPEED) > 11'(SCREEN_W) && !hit_r;
    x_d        = hit_l ? 10'(F) : hit_r ? 10'(AI_X - BALL_SIZE) : dx_q ? x_q + 10'(SPEED) : x_q - 10'(SPEED);
    y_d        = !dy_q && ye < 11'(SPEED) ? '0 :
                 dy_q && ye + 11'(SPEED) > 11'(YMAX) ? 10'(YMAX) :
                 dy_q ? y_q + 10'(SPEED) : y_q - 10'(SPEED);
    dy_d       = !dy_q && ye < 11'(SPEED) ? 1'b1 : dy_q && ye + 11'(SPEED) > 11'(YMAX) ? 1'b0 : dy_q;
    ps_n       = ps_q + 4'(ps_q < 4'(WIN_SCORE));
    as_n       = as_q + 4'(as_q < 4'(WIN_SCORE));
    win        = (miss_r ? ps_n : as_n) == 4'(WIN_SCORE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SERVE;
      step_q  <= '0;
      serve_q <= '0;
      x_q     <= 10'(CX);
      y_q     <= 10'(CY);
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      ps_q    <= '0;
      as_q    <= '0;
      hit_q   <= 1'b0;
      pp_q    <= 1'b0;
      pa_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      pp_q   <= 1'b0;
      pa_q   <= 1'b0;
      step_q <= strobe ? '0 : step_q + SW'(1);
      if (strobe) begin
        case (state_q)
          SERVE: begin
            serve_q <= serve_done ? '0 : serve_q + VW'(1);
            if (serve_done) state_q <= PLAY;
          end
          PLAY: begin
            if (miss_l || miss_r) begin
              // a miss recentres, keeps dir_y and serves toward the side that lost
              x_q     <= 10'(CX);
              y_q     <= 10'(CY);
              dx_q    <= miss_r;
              serve_q <= '0;
              ps_q    <= miss_r ? ps_n : ps_q;
              as_q    <= miss_l ? as_n : as_q;
              pp_q    <= miss_r;
              pa_q    <= miss_l;
              go_q    <= win;
              state_q <= win ? OVER : SERVE;
            end else begin
              x_q   <= x_d;
              y_q   <= y_d;
              dx_q  <= hit_l ? 1'b1 : hit_r ? 1'b0 : dx_q;
              dy_q  <= dy_d;
              hit_q <= hit_l || hit_r;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign bus.ball_pos_x   = x_q;
  assign bus.ball_pos_y   = y_q;
  assign bus.player_score = ps_q;
  assign bus.ai_score     = as_q;
  assign bus.paddle_hit   = hit_q;
  assign bus.point_player = pp_q;
  assign bus.point_ai     = pa_q;
  assign bus.game_over    = go_q;
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: scoreboard bench with a behavioural game model plus directed checks of serve, bounce, hits, misses and reset.
module tb_ball_motion;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ball_motion_if bus();
  ball_motion #(.STEP_DIV(1), .SERVE_STEPS(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  int mx, my, mdx, mdy, mps, mas, mst, msv, mhit, mpp, mpa, mgo;
  int cnt_hit, cnt_pp, cnt_pa, max_y;
  bit trk_p = 0, trk_a = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] obs();
    return {bus.ball_pos_x, bus.ball_pos_y, bus.player_score, bus.ai_score,
            bus.paddle_hit, bus.point_player, bus.point_ai, bus.game_over};
  endfunction
  task automatic model();
    int ny, ndy, pp, ap, score;
    bit ovp, ova, miss;
    mhit = 0; mpp = 0; mpa = 0;
    if (reset) begin
      mx = 316; my = 236; mdx = 1; mdy = 1; mps = 0; mas = 0; mst = 0; msv = 0; mgo = 0;
    end else if (mst == 0) begin
      if (msv == 3) begin mst = 1; msv = 0; end else msv++;
    end else if (mst == 1) begin
      pp = int'(bus.player_paddle);
      ap = int'(bus.ai_paddle);
      if (mdy == 0 && my < 2) begin ny = 0; ndy = 1; end
      else if (mdy == 1 && my + 2 > 472) begin ny = 472; ndy = 0; end
      else begin ny = mdy ? my + 2 : my - 2; ndy = mdy; end
      ovp = (my + 8 > pp) && (my < pp + 64);
      ova = (my + 8 > ap) && (my < ap + 64);
      miss = 0;
      if (mdx == 0) begin
        if (mx >= 24 && mx - 2 < 24 && ovp) begin mx = 24; mdx = 1; mhit = 1; end
        else if (mx < 2) begin miss = 1; if (mas < 7) mas++; mpa = 1; mdx = 0; score = mas; end
        else mx = mx - 2;
      end else begin
        if (mx + 8 <= 616 && mx + 10 > 616 && ova) begin mx = 608; mdx = 0; mhit = 1; end
        else if (mx + 10 > 640) begin miss = 1; if (mps < 7) mps++; mpp = 1; mdx = 1; score = mps; end
        else mx = mx + 2;
      end
      if (miss) begin
        mx = 316; my = 236; msv = 0;
        mst = (score == 7) ? 2 : 0;
        mgo = (score == 7);
      end else begin
        my = ny; mdy = ndy;
      end
    end
  endtask
  task automatic tick();
    logic [31:0] e;
    if (trk_p) bus.player_paddle = 10'(my >= 20 ? my - 20 : 0);
    if (trk_a) bus.ai_paddle = 10'(my >= 20 ? my - 20 : 0);
    model();
    exp_q.push_back({10'(mx), 10'(my), 4'(mps), 4'(mas), 1'(mhit), 1'(mpp), 1'(mpa), 1'(mgo)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("cycle", obs(), e);
    cnt_hit += int'(bus.paddle_hit);
    cnt_pp  += int'(bus.point_player);
    cnt_pa  += int'(bus.point_ai);
    if (int'(bus.ball_pos_y) > max_y) max_y = int'(bus.ball_pos_y);
  endtask
  initial begin
    bus.player_paddle = '0;
    bus.ai_paddle = '0;
    reset = 1'b1;
    tick(); tick();
    chk("rst_x", 32'(bus.ball_pos_x), 316);
    chk("rst_y", 32'(bus.ball_pos_y), 236);
    chk("rst_scores", {bus.player_score, bus.ai_score}, 0);
    chk("rst_flags", {bus.paddle_hit, bus.point_player, bus.point_ai, bus.game_over}, 0);
    reset = 1'b0;
    repeat (4) tick();
    chk("serve_hold", {bus.ball_pos_x, bus.ball_pos_y}, {10'd316, 10'd236});
    tick();
    chk("first_move", {bus.ball_pos_x, bus.ball_pos_y}, {10'd318, 10'd238});
    max_y = 0; cnt_pp = 0;
    for (int i = 0; i < 400 && !bus.point_player; i++) tick();
    chk("miss_r_seen", 32'(bus.point_player), 1);
    chk("bottom_clamp", 32'(max_y), 472);
    chk("miss_r_score", 32'(bus.player_score), 1);
    chk("miss_r_centre", {bus.ball_pos_x, bus.ball_pos_y}, {10'd316, 10'd236});
    chk("miss_r_pulses", 32'(cnt_pp), 1);
    cnt_hit = 0; trk_a = 1;
    for (int i = 0; i < 600 && !bus.paddle_hit; i++) tick();
    chk("hit_r_seen", 32'(bus.paddle_hit), 1);
    chk("hit_r_x", 32'(bus.ball_pos_x), 608);
    tick();
    chk("hit_r_ret", 32'(bus.ball_pos_x), 606);
    chk("hit_r_once", 32'(cnt_hit), 1);
    trk_a = 0; bus.ai_paddle = '0; trk_p = 1; cnt_hit = 0;
    for (int i = 0; i < 600 && !bus.paddle_hit; i++) tick();
    chk("hit_l_seen", 32'(bus.paddle_hit), 1);
    chk("hit_l_x", 32'(bus.ball_pos_x), 24);
    tick();
    chk("hit_l_ret", 32'(bus.ball_pos_x), 26);
    chk("hit_l_once", 32'(cnt_hit), 1);
    trk_p = 0; bus.player_paddle = 10'd1000; trk_a = 1;
    for (int i = 0; i < 700 && !bus.paddle_hit; i++) tick();
    chk("hit_r2_x", 32'(bus.ball_pos_x), 608);
    trk_a = 0; bus.ai_paddle = 10'd1000; cnt_pa = 0;
    for (int i = 0; i < 800 && !bus.point_ai; i++) tick();
    chk("miss_l_seen", 32'(bus.point_ai), 1);
    chk("miss_l_score", 32'(bus.ai_score), 1);
    chk("miss_l_centre", {bus.ball_pos_x, bus.ball_pos_y}, {10'd316, 10'd236});
    for (int i = 0; i < 1000 && bus.ai_score != 4'd3; i++) tick();
    chk("ai_score3", 32'(bus.ai_score), 3);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midplay_rst_pos", {bus.ball_pos_x, bus.ball_pos_y}, {10'd316, 10'd236});
    chk("midplay_rst_scores", {bus.player_score, bus.ai_score}, 0);
    chk("midplay_rst_flags", {bus.paddle_hit, bus.point_player, bus.point_ai, bus.game_over}, 0);
    cnt_pp = 0;
    for (int i = 0; i < 3000 && !bus.game_over; i++) tick();
    chk("game_over", 32'(bus.game_over), 1);
    chk("final_score", 32'(bus.player_score), 7);
    chk("win_pulses", 32'(cnt_pp), 7);
    cnt_hit = 0; cnt_pp = 0; cnt_pa = 0;
    repeat (50) tick();
    chk("over_frozen", {bus.ball_pos_x, bus.ball_pos_y}, {10'd316, 10'd236});
    chk("over_quiet", 32'(cnt_hit + cnt_pp + cnt_pa), 0);
    chk("over_sat", 32'(bus.player_score), 7);
    reset = 1'b1;
    tick();
    chk("over_rst", {bus.game_over, bus.player_score}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ball_motion.md
# ball_motion

Ball physics and scoring engine for the Pong datapath. Consumes the paddle positions driven by `paddles` and produces the ball position that `paddles` consumes: the other end of the paddle/ball interface. Moves the ball on a divided step strobe, reflects it off the top and bottom walls and both paddles, detects misses, keeps both scores and sequences serve, play and game-over. Outputs feed `paddles` (`ball_pos_y`) and the VGA renderer.

## Interface
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels.
- `BALL_SIZE`, 8: ball edge length (square).
- `PADDLE_W`, 8: paddle width.
- `PADDLE_H`, 64: paddle height.
- `PLAYER_X`, 16: left x of the player paddle (left side).
- `AI_X`, 616: left x of the AI paddle (right side).
- `SPEED`, 2: pixels moved per step, per axis.
- `STEP_DIV`, 416667: clocks per step (≥1).
- `SERVE_STEPS`, 60: steps the ball rests at centre before moving.
- `WIN_SCORE`, 7: score that ends the game.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `player_paddle` in 10: top y of player paddle.
- `ai_paddle` in 10: top y of AI paddle.
- `ball_pos_x` out 10: ball top-left x.
- `ball_pos_y` out 10: ball top-left y.
- `player_score` out 4: player points.
- `ai_score` out 4: AI points.
- `paddle_hit` out 1: one-clock pulse on any paddle reflection.
- `point_player` out 1: one-clock pulse when the player scores.
- `point_ai` out 1: one-clock pulse when the AI scores.
- `game_over` out 1: high once either score reaches `WIN_SCORE`.

## Operation
- Step strobe: counter runs 0..STEP_DIV-1 and wraps. The strobe is the clock edge where the counter equals STEP_DIV-1. All position and state updates occur only on strobe edges.
- Centre: CX = (SCREEN_W-BALL_SIZE)/2 = 316; CY = (SCREEN_H-BALL_SIZE)/2 = 236.
- Direction: `dir_x` is 1 for right; `dir_y` is 1 for down.
- States:
  - SERVE: ball held at (CX,CY); serve counter counts strobes. After SERVE_STEPS strobes, go to PLAY. The first move happens on the next strobe.
  - PLAY: ball moves every strobe.
  - OVER: ball held at centre, `game_over`=1, no pulses. Only `reset` exits.
- Vertical rule, PLAY:
  - Moving up with y < SPEED: y←0, dir_y←down.
  - Moving down with y+SPEED > SCREEN_H-BALL_SIZE: y←SCREEN_H-BALL_SIZE, dir_y←up.
  - Otherwise y moves by ±SPEED.
- Overlap(p) is true when ball_y+BALL_SIZE > p and ball_y < p+PADDLE_H. Evaluate on current registers in 11-bit arithmetic.
- Left face F = PLAYER_X+PADDLE_W. Moving left with x ≥ F, x−SPEED < F and Overlap(player_paddle): x←F, dir_x←right, pulse `paddle_hit`.
- Right face: moving right with x+BALL_SIZE ≤ AI_X, x+BALL_SIZE+SPEED > AI_X and Overlap(ai_paddle): x←AI_X−BALL_SIZE, dir_x←left, pulse `paddle_hit`.
- Miss left: moving left, x < SPEED, no hit. Result: `ai_score`+1, pulse `point_ai`, dir_x←left (serve toward the loser).
- Miss right: moving right, x+BALL_SIZE+SPEED > SCREEN_W, no hit. Result: `player_score`+1, pulse `point_player`, dir_x←right.
- After a miss, the ball recentres and the state goes to SERVE. If the new score equals WIN_SCORE, go to OVER instead. The vertical update is discarded and dir_y is kept.
- The x and y axes resolve independently on the same strobe, so a wall bounce plus a paddle hit both apply. A miss overrides the y update.
- Scores saturate at WIN_SCORE.

## Timing
- Reset values:
  - ball (316,236), scores 0, all pulses 0, `game_over` 0.
  - state SERVE, dir_x right, dir_y down, step and serve counters 0.
- All outputs are registered. A pulse is high for exactly the one clock following its strobe edge.
- Paddle inputs are sampled on the strobe edge only; no synchronisation is required.
- `reset` asserted mid-PLAY or mid-SERVE restores every reset value on the next edge. Any pending pulse is dropped.
- With STEP_DIV=1, every clock is a strobe.

## Test plan
Bench uses STEP_DIV=1, SERVE_STEPS=4.
- Reset, then release → outputs hold (316,236) for 4 clocks; the 5th clock gives (318,238); scores 0.
- Both paddles at y=0, free run → y reaches 472, clamps at 472 and dir_y flips. Ball then misses right: `point_player` pulses once, `player_score`=1, ball returns to (316,236).
- Continuously drive `ai_paddle` = ball_pos_y−20 → on arrival, x is clamped to 608, `paddle_hit` pulses once and x then decreases by 2 per clock.
- Drive `player_paddle` = ball_pos_y−20 on the return → x clamps to 24, `paddle_hit` pulses and dir_x is right.
- Leave both paddles away for 7 consecutive misses → scores reach 7. `game_over`=1, ball frozen at (316,236), no further pulses until `reset`.
- Assert `reset` for one clock mid-PLAY with score 3 → next clock: (316,236), scores 0, all pulses 0.
